ibc_read_ctrl: RTL and testbench

Input buffer controller for the read path. It collects single-word read requests from `nPorts` processing cores through a rotating token and queues them toward the memory interface (MIF). It tracks outstanding reads in order and routes each returned data word back to the core that issued it. It is the read-side counterpart of the output buffer controller and sits between the port crossbar and the MIF.

---
 rtl/ibc_read_ctrl_if.sv | 47 ++++
 rtl/ibc_read_ctrl.sv | 116 +++++++++++
 tb/tb_ibc_read_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ibc_read_ctrl_if.sv
// Port bundle for the read-path input buffer controller: core token/request side,
// MIF request/response side and the shared read-data broadcast.
interface ibc_read_ctrl_if #(
    parameter int unsigned nPorts     = 2,
    parameter int unsigned wAddrWidth = 28,
    parameter int unsigned wDataWidth = 64
);
    logic [nPorts-1:0]     tk_out;
    logic                  r_req_en;
    logic [wAddrWidth-1:0] r_req_addr;
    logic [wAddrWidth-1:0] ibc2mem_r_addr;
    logic                  ibc2mem_r_vld;
    logic                  mem2ibc_en;
    logic                  mem2ibc_r_vld;
    logic [wDataWidth-1:0] mem2ibc_r_data;
    logic [wDataWidth-1:0] r_data;
    logic [nPorts-1:0]     r_data_vld;
    logic                  rsp_err;

    modport master (
        output tk_out,
        input  r_req_en,
        input  r_req_addr,
        output ibc2mem_r_addr,
        output ibc2mem_r_vld,
        input  mem2ibc_en,
        input  mem2ibc_r_vld,
        input  mem2ibc_r_data,
        output r_data,
        output r_data_vld,
        output rsp_err
    );

    modport slave (
        input  tk_out,
        output r_req_en,
        output r_req_addr,
        input  ibc2mem_r_addr,
        input  ibc2mem_r_vld,
        output mem2ibc_en,
        output mem2ibc_r_vld,
        output mem2ibc_r_data,
        input  r_data,
        input  r_data_vld,
        input  rsp_err
    );
endinterface

// File: rtl/ibc_read_ctrl.sv
// Read-path input buffer controller: token-arbitrated request queue toward the MIF and
// an in-order tag queue that steers returned data back to the issuing core.
module ibc_read_ctrl #(
    parameter int unsigned nPorts     = 2,
    parameter int unsigned wAddrWidth = 28,
    parameter int unsigned wDataWidth = 64,
    parameter int unsigned REQ_DEPTH  = 4,
    parameter int unsigned MAX_OUT    = 4
) (
    input logic            clk_bus,
    input logic            rst_bus,
    ibc_read_ctrl_if.master bus
);
    localparam int unsigned PidW    = (nPorts > 1) ? $clog2(nPorts) : 1;
    localparam int unsigned ReqPtrW = $clog2(REQ_DEPTH);
    localparam int unsigned ReqCntW = $clog2(REQ_DEPTH) + 1;
    localparam int unsigned TagPtrW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned TagCntW = $clog2(MAX_OUT) + 1;

    logic [PidW-1:0]       req_pid_mem  [REQ_DEPTH];
    logic [wAddrWidth-1:0] req_addr_mem [REQ_DEPTH];
    logic [ReqPtrW-1:0]    req_wptr, req_rptr;
    logic [ReqCntW-1:0]    req_cnt;

    logic [PidW-1:0]       tag_mem [MAX_OUT];
    logic [TagPtrW-1:0]    tag_wptr, tag_rptr;
    logic [TagCntW-1:0]    tag_cnt;

    logic [PidW-1:0]       tk_count;
    logic [wAddrWidth-1:0] last_head;
    logic [wDataWidth-1:0] r_data_q;
    logic [nPorts-1:0]     r_data_vld_q;
    logic                  rsp_err_q;

    logic                  issuable, req_empty, tag_full, tag_empty;
    logic                  req_push, issue_vld, issue, tag_pop;
    logic [nPorts-1:0]     tk_vec, rsp_onehot;
    logic [wAddrWidth-1:0] head_addr;
    logic [PidW-1:0]       head_pid, tag_head;

    assign issuable  = req_cnt < ReqCntW'(REQ_DEPTH);
    assign req_empty = (req_cnt == '0);
    assign tag_full  = (tag_cnt == TagCntW'(MAX_OUT));
    assign tag_empty = (tag_cnt == '0);
    assign head_addr = req_addr_mem[req_rptr];
    assign head_pid  = req_pid_mem[req_rptr];
    assign tag_head  = tag_mem[tag_rptr];

    assign req_push  = bus.r_req_en && issuable;
    assign issue_vld = !req_empty && !tag_full;
    assign issue     = issue_vld && bus.mem2ibc_en;
    assign tag_pop   = bus.mem2ibc_r_vld && !tag_empty;

    always_comb begin
        tk_vec     = '0;
        rsp_onehot = '0;
        for (int i = 0; i < int'(nPorts); i++) begin
            tk_vec[i]     = issuable && (tk_count == PidW'(i));
            rsp_onehot[i] = (tag_head == PidW'(i));
        end
    end

    assign bus.tk_out         = tk_vec;
    assign bus.ibc2mem_r_vld  = issue_vld;
    // Hold the last head when the queue drains so the MIF address bus stays quiet.
    assign bus.ibc2mem_r_addr = req_empty ? last_head : head_addr;
    assign bus.r_data         = r_data_q;
    assign bus.r_data_vld     = r_data_vld_q;
    assign bus.rsp_err        = rsp_err_q;

    always_ff @(posedge clk_bus) begin
        if (req_push) begin
            req_pid_mem[req_wptr]  <= tk_count;
            req_addr_mem[req_wptr] <= bus.r_req_addr;
        end
        if (issue) begin
            tag_mem[tag_wptr] <= head_pid;
        end
    end

    always_ff @(posedge clk_bus) begin
        if (rst_bus) begin
            req_wptr     <= '0;
            req_rptr     <= '0;
            req_cnt      <= '0;
            tag_wptr     <= '0;
            tag_rptr     <= '0;
            tag_cnt      <= '0;
            tk_count     <= '0;
            last_head    <= '0;
            r_data_q     <= '0;
            r_data_vld_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            if (issuable) begin
                tk_count <= (tk_count == PidW'(nPorts - 1)) ? '0 : tk_count + 1'b1;
            end
            if (req_push) req_wptr <= req_wptr + 1'b1;
            if (issue)    req_rptr <= req_rptr + 1'b1;
            req_cnt <= req_cnt + ReqCntW'(req_push) - ReqCntW'(issue);
            if (!req_empty) last_head <= head_addr;

            if (issue) begin
                tag_wptr <= (tag_wptr == TagPtrW'(MAX_OUT - 1)) ? '0 : tag_wptr + 1'b1;
            end
            if (tag_pop) begin
                tag_rptr <= (tag_rptr == TagPtrW'(MAX_OUT - 1)) ? '0 : tag_rptr + 1'b1;
            end
            tag_cnt <= tag_cnt + TagCntW'(issue) - TagCntW'(tag_pop);

            r_data_vld_q <= tag_pop ? rsp_onehot : '0;
            if (tag_pop) r_data_q <= bus.mem2ibc_r_data;
            if (bus.mem2ibc_r_vld && tag_empty) rsp_err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ibc_read_ctrl.sv
// Directed bench for ibc_read_ctrl: MIF issue addresses and core responses are checked
// by a scoreboard monitor; token, stall and error behaviour by inline checks.
module tb_ibc_read_ctrl;
    localparam int unsigned NP = 2;
    localparam int unsigned AW = 28;
    localparam int unsigned DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ibc_read_ctrl_if #(.nPorts(NP), .wAddrWidth(AW), .wDataWidth(DW)) bus ();

    ibc_read_ctrl #(
        .nPorts    (NP),
        .wAddrWidth(AW),
        .wDataWidth(DW),
        .REQ_DEPTH (4),
        .MAX_OUT   (4)
    ) u_dut (
        .clk_bus(clk),
        .rst_bus(rst),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] exp_addr [$];
    logic [NP-1:0] exp_port [$];
    logic [DW-1:0] exp_data [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fail_unexpected(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=0x%0h required=none", name, act);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rsp(input logic [NP-1:0] port, input logic [DW-1:0] data);
        exp_port.push_back(port);
        exp_data.push_back(data);
    endtask

    // Scoreboard monitor, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ibc2mem_r_vld === 1'b1 && bus.mem2ibc_en === 1'b1) begin
                if (exp_addr.size() == 0) fail_unexpected("mif_issue", 64'(bus.ibc2mem_r_addr));
                else check("mif_addr", 64'(bus.ibc2mem_r_addr), 64'(exp_addr.pop_front()));
            end
            if (bus.r_data_vld !== '0) begin
                if (exp_port.size() == 0) begin
                    fail_unexpected("rsp_vld", 64'(bus.r_data_vld));
                end else begin
                    check("rsp_port", 64'(bus.r_data_vld), 64'(exp_port.pop_front()));
                    check("rsp_data", bus.r_data, exp_data.pop_front());
                end
            end
        end
    end

    logic [NP-1:0] s_oh, sb_oh;
    int n;

    initial begin
        bus.r_req_en       = 1'b0;
        bus.r_req_addr     = '0;
        bus.mem2ibc_en     = 1'b0;
        bus.mem2ibc_r_vld  = 1'b0;
        bus.mem2ibc_r_data = '0;
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;

        // Reset state
        check("rst_tk_out", 64'(bus.tk_out), 64'h1);
        check("rst_mif_vld", 64'(bus.ibc2mem_r_vld), 64'h0);
        check("rst_mif_addr", 64'(bus.ibc2mem_r_addr), 64'h0);
        check("rst_r_data_vld", 64'(bus.r_data_vld), 64'h0);
        check("rst_r_data", bus.r_data, 64'h0);
        check("rst_rsp_err", 64'(bus.rsp_err), 64'h0);

        // Idle token rotation
        for (int k = 0; k < 4; k++) begin
            check("idle_tk_out", 64'(bus.tk_out), (k % 2 == 0) ? 64'h1 : 64'h2);
            check("idle_mif_vld", 64'(bus.ibc2mem_r_vld), 64'h0);
            check("idle_r_data_vld", 64'(bus.r_data_vld), 64'h0);
            cyc();
        end

        // Two cores, one request each, in-order responses
        bus.mem2ibc_en = 1'b1;
        check("t2_tk_core0", 64'(bus.tk_out), 64'h1);
        bus.r_req_en   = 1'b1;
        bus.r_req_addr = 28'h100;
        exp_addr.push_back(28'h100);
        cyc();
        check("t2_vld_next", 64'(bus.ibc2mem_r_vld), 64'h1);
        check("t2_addr_next", 64'(bus.ibc2mem_r_addr), 64'h100);
        check("t2_tk_core1", 64'(bus.tk_out), 64'h2);
        bus.r_req_addr = 28'h200;
        exp_addr.push_back(28'h200);
        cyc();
        bus.r_req_en = 1'b0;
        cyc();
        bus.mem2ibc_r_vld  = 1'b1;
        bus.mem2ibc_r_data = 64'hA;
        push_rsp(2'b01, 64'hA);
        cyc();
        check("t2_rsp0_vld", 64'(bus.r_data_vld), 64'h1);
        check("t2_rsp0_data", bus.r_data, 64'hA);
        bus.mem2ibc_r_data = 64'hB;
        push_rsp(2'b10, 64'hB);
        cyc();
        bus.mem2ibc_r_vld = 1'b0;
        check("t2_rsp1_vld", 64'(bus.r_data_vld), 64'h2);
        check("t2_rsp1_data", bus.r_data, 64'hB);
        cyc();
        check("t2_rsp_one_cycle", 64'(bus.r_data_vld), 64'h0);
        check("t2_no_err", 64'(bus.rsp_err), 64'h0);

        // Fill request FIFO with MIF stalled; token freezes
        bus.mem2ibc_en = 1'b0;
        s_oh  = bus.tk_out;
        sb_oh = s_oh ^ 2'b11;
        for (int k = 0; k < 4; k++) begin
            bus.r_req_en   = 1'b1;
            bus.r_req_addr = AW'(28'h300 + k);
            exp_addr.push_back(AW'(28'h300 + k));
            cyc();
        end
        bus.r_req_en = 1'b0;
        check("t3_tk_frozen0", 64'(bus.tk_out), 64'h0);
        check("t3_vld_stalled", 64'(bus.ibc2mem_r_vld), 64'h1);
        cyc();
        check("t3_tk_frozen1", 64'(bus.tk_out), 64'h0);
        bus.mem2ibc_en = 1'b1;
        cyc();
        bus.mem2ibc_en = 1'b0;
        check("t3_tk_resume", 64'(bus.tk_out), 64'(s_oh));

        // Outstanding limit: four issued, fifth blocked until a response
        bus.r_req_en   = 1'b1;
        bus.r_req_addr = 28'h304;
        exp_addr.push_back(28'h304);
        bus.mem2ibc_en = 1'b1;
        cyc();
        bus.r_req_en = 1'b0;
        cyc();
        cyc();
        check("t4_vld_blocked", 64'(bus.ibc2mem_r_vld), 64'h0);
        check("t4_addr_head", 64'(bus.ibc2mem_r_addr), 64'h304);
        cyc();
        check("t4_vld_still_blocked", 64'(bus.ibc2mem_r_vld), 64'h0);
        bus.mem2ibc_r_vld  = 1'b1;
        bus.mem2ibc_r_data = 64'hC1;
        push_rsp(s_oh, 64'hC1);
        cyc();
        check("t4_vld_resumes", 64'(bus.ibc2mem_r_vld), 64'h1);
        check("t4_addr_fifth", 64'(bus.ibc2mem_r_addr), 64'h304);
        for (int k = 0; k < 4; k++) begin
            bus.mem2ibc_r_data = DW'(64'hC2 + k);
            push_rsp((k % 2 == 0) ? sb_oh : s_oh, DW'(64'hC2 + k));
            cyc();
        end
        bus.mem2ibc_r_vld = 1'b0;
        bus.mem2ibc_en    = 1'b0;
        cyc();
        cyc();

        // Response with nothing outstanding, then reset clears the sticky error
        check("t5_err_before", 64'(bus.rsp_err), 64'h0);
        bus.mem2ibc_r_vld  = 1'b1;
        bus.mem2ibc_r_data = 64'hDEAD;
        cyc();
        bus.mem2ibc_r_vld = 1'b0;
        check("t5_err_set", 64'(bus.rsp_err), 64'h1);
        check("t5_no_data_vld", 64'(bus.r_data_vld), 64'h0);
        cyc();
        check("t5_err_sticky", 64'(bus.rsp_err), 64'h1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("t5_err_cleared", 64'(bus.rsp_err), 64'h0);
        check("t5_tk_after_rst", 64'(bus.tk_out), 64'h1);

        // Request strobe without a token is ignored
        for (int k = 0; k < 4; k++) begin
            bus.r_req_en   = 1'b1;
            bus.r_req_addr = AW'(28'h400 + k);
            exp_addr.push_back(AW'(28'h400 + k));
            cyc();
        end
        bus.r_req_addr = 28'hBAD;
        for (int k = 0; k < 3; k++) begin
            check("t6_tk_none", 64'(bus.tk_out), 64'h0);
            cyc();
        end
        bus.r_req_en   = 1'b0;
        bus.mem2ibc_en = 1'b1;
        n = 0;
        while (exp_addr.size() != 0 && n < 20) begin
            cyc();
            n++;
        end
        check("t6_drain_left", 64'(exp_addr.size()), 64'h0);
        for (int k = 0; k < 4; k++) begin
            bus.mem2ibc_r_vld  = 1'b1;
            bus.mem2ibc_r_data = DW'(64'hE0 + k);
            push_rsp((k % 2 == 0) ? 2'b01 : 2'b10, DW'(64'hE0 + k));
            cyc();
        end
        bus.mem2ibc_r_vld = 1'b0;
        repeat (4) cyc();
        check("t6_no_ghost_issue", 64'(bus.ibc2mem_r_vld), 64'h0);
        check("t6_last_head", 64'(bus.ibc2mem_r_addr), 64'h403);
        check("end_rsp_left", 64'(exp_port.size()), 64'h0);
        check("end_rsp_err", 64'(bus.rsp_err), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
